// File: rtl/vram_arbiter.sv
// Fixed-priority VRAM arbiter: the display port wins, and the CPU port gets every free slot.
// Define VRAM_ARB_STARVE_GUARD_EN to force a CPU grant after STARVE_LIMIT waiting cycles.
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              CLK100MHz,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_wait
);

  typedef enum logic [1:0] {IDLE, DISP, CPU} state_t;

  state_t state, state_next;
  logic   disp_elig, cpu_elig, force_cpu;
  logic   tag1_valid, tag1_cpu, tag2_valid, tag2_cpu;

  generate
    if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("vram_arbiter: STARVE_LIMIT must be at least 1");
    end
  endgenerate

  // The grant state doubles as the ack register, so a held request is masked for one cycle
  assign disp_ack = (state == DISP);
  assign cpu_ack  = (state == CPU);
  assign mem_en   = (state != IDLE);
  assign cpu_wait = cpu_req & ~cpu_ack;

  assign disp_elig = disp_req & ~disp_ack;
  assign cpu_elig  = cpu_req & ~cpu_ack;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge CLK100MHz or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (cpu_ack)
      starve_cnt <= '0;
    else if (cpu_wait && (starve_cnt != CNT_W'(STARVE_LIMIT)))
      starve_cnt <= starve_cnt + 1'b1;
  end

  assign force_cpu = (starve_cnt == CNT_W'(STARVE_LIMIT)) & cpu_elig;
`else
  assign force_cpu = 1'b0;
`endif

  always_comb begin
    state_next = IDLE;
    if (force_cpu)
      state_next = CPU;
    else if (disp_elig)
      state_next = DISP;
    else if (cpu_elig)
      state_next = CPU;
  end

  always_ff @(posedge CLK100MHz or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Address and write data hold through idle cycles; only the strobes drop
  always_ff @(posedge CLK100MHz or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_next)
        DISP: begin
          mem_we   <= 1'b0;
          mem_addr <= disp_addr;
        end
        CPU: begin
          mem_we   <= cpu_we;
          mem_addr <= cpu_addr;
          if (cpu_we)
            mem_wdata <= cpu_wdata;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  // Stage 1 rides with mem_en, stage 2 with mem_rdata
  always_ff @(posedge CLK100MHz or negedge rst) begin
    if (!rst) begin
      tag1_valid <= 1'b0;
      tag1_cpu   <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_cpu   <= 1'b0;
    end else begin
      tag1_valid <= (state_next == DISP) | ((state_next == CPU) & ~cpu_we);
      tag1_cpu   <= (state_next == CPU);
      tag2_valid <= tag1_valid;
      tag2_cpu   <= tag1_cpu;
    end
  end

  always_ff @(posedge CLK100MHz or negedge rst) begin
    if (!rst) begin
      disp_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
      disp_rdata  <= '0;
      cpu_rdata   <= '0;
    end else begin
      disp_rvalid <= tag2_valid & ~tag2_cpu;
      cpu_rvalid  <= tag2_valid & tag2_cpu;
      if (tag2_valid && !tag2_cpu)
        disp_rdata <= mem_rdata;
      if (tag2_valid && tag2_cpu)
        cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a one-cycle-latency RAM model.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        disp_ack;
  logic [7:0]  disp_rdata;
  logic        disp_rvalid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        cpu_wait;

  logic [7:0]  ram [0:65535];
  int          checks = 0;
  int          errors = 0;
  logic        prev_disp_pend, prev_cpu_pend;

  vram_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(8)) dut (
    .CLK100MHz(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_wait(cpu_wait)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        ram[mem_addr] <= mem_wdata;
      else
        mem_rdata <= ram[mem_addr];
    end
  end

  // A request may only be withdrawn once its ack has been seen
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_disp_pend <= 1'b0;
      prev_cpu_pend  <= 1'b0;
    end else begin
      assert (!prev_disp_pend || disp_req || disp_ack) else $error("[TB] disp_req dropped before disp_ack");
      assert (!prev_cpu_pend || cpu_req || cpu_ack) else $error("[TB] cpu_req dropped before cpu_ack");
      prev_disp_pend <= disp_req & ~disp_ack;
      prev_cpu_pend  <= cpu_req & ~cpu_ack;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic dreq, input logic [15:0] daddr, input logic creq,
                               input logic cwe, input logic [15:0] caddr, input logic [7:0] cwdata);
    disp_req  = dreq;
    disp_addr = daddr;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwdata;
  endtask

  initial begin
    rst = 1'b0;
    mem_rdata = 8'h00;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    ram[16'h0050] = 8'h5A;
    ram[16'h0123] = 8'hA5;
    ram[16'h0010] = 8'h11;
    ram[16'h0020] = 8'h22;
    ram[16'h0030] = 8'h33;
    ram[16'h0040] = 8'h44;

    repeat (2) @(negedge clk);
    checkOutput("reset_mem_en", mem_en, 1'b0);
    checkOutput("reset_disp_ack", disp_ack, 1'b0);
    checkOutput("reset_cpu_ack", cpu_ack, 1'b0);
    checkOutput("reset_cpu_wait", cpu_wait, 1'b0);
    rst = 1'b1;

    // Reset asserted while a display read is on the RAM
    @(negedge clk) applyStimulus(1'b1, 16'h0050, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    checkOutput("pre_reset_mem_en", mem_en, 1'b1);
    checkOutput("pre_reset_mem_addr", mem_addr, 16'h0050);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    rst = 1'b0;
    #1;
    checkOutput("async_mem_en", mem_en, 1'b0);
    checkOutput("async_disp_ack", disp_ack, 1'b0);
    checkOutput("async_mem_addr", mem_addr, 16'h0);
    checkOutput("async_mem_we", mem_we, 1'b0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_reset_disp_rvalid", disp_rvalid, 1'b0);
      checkOutput("post_reset_cpu_rvalid", cpu_rvalid, 1'b0);
    end

    // Single display read
    @(negedge clk) applyStimulus(1'b1, 16'h0123, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    checkOutput("disp_ack", disp_ack, 1'b1);
    checkOutput("disp_mem_en", mem_en, 1'b1);
    checkOutput("disp_mem_addr", mem_addr, 16'h0123);
    checkOutput("disp_mem_we", mem_we, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    checkOutput("disp_ack_pulse", disp_ack, 1'b0);
    checkOutput("disp_idle_mem_en", mem_en, 1'b0);
    checkOutput("disp_early_rvalid", disp_rvalid, 1'b0);
    @(negedge clk);
    checkOutput("disp_rvalid", disp_rvalid, 1'b1);
    checkOutput("disp_rdata", disp_rdata, 8'hA5);
    @(negedge clk);
    checkOutput("disp_rvalid_pulse", disp_rvalid, 1'b0);
    checkOutput("disp_rdata_hold", disp_rdata, 8'hA5);

    // CPU write then read back
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h4000, 8'h3C);
    #1 checkOutput("cpu_wait_pending", cpu_wait, 1'b1);
    @(negedge clk);
    checkOutput("wr_cpu_ack", cpu_ack, 1'b1);
    checkOutput("wr_mem_we", mem_we, 1'b1);
    checkOutput("wr_mem_addr", mem_addr, 16'h4000);
    checkOutput("wr_mem_wdata", mem_wdata, 8'h3C);
    checkOutput("wr_cpu_wait", cpu_wait, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("wr_no_rvalid", cpu_rvalid, 1'b0);
    end
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h4000, 8'h00);
    @(negedge clk);
    checkOutput("rd_cpu_ack", cpu_ack, 1'b1);
    checkOutput("rd_mem_we", mem_we, 1'b0);
    checkOutput("rd_mem_wdata_hold", mem_wdata, 8'h3C);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    checkOutput("rd_early_rvalid", cpu_rvalid, 1'b0);
    @(negedge clk);
    checkOutput("rd_cpu_rvalid", cpu_rvalid, 1'b1);
    checkOutput("rd_cpu_rdata", cpu_rdata, 8'h3C);
    repeat (2) @(negedge clk);

    // Simultaneous requests: display first, CPU in the next slot
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 8'h00);
    @(negedge clk);
    checkOutput("sim_disp_ack", disp_ack, 1'b1);
    checkOutput("sim_cpu_ack_low", cpu_ack, 1'b0);
    checkOutput("sim_addr_disp", mem_addr, 16'h0010);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 8'h00);
    @(negedge clk);
    checkOutput("sim_cpu_ack", cpu_ack, 1'b1);
    checkOutput("sim_disp_ack_low", disp_ack, 1'b0);
    checkOutput("sim_addr_cpu", mem_addr, 16'h0020);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    checkOutput("sim_disp_rvalid", disp_rvalid, 1'b1);
    checkOutput("sim_disp_rdata", disp_rdata, 8'h11);
    checkOutput("sim_cpu_rvalid_early", cpu_rvalid, 1'b0);
    @(negedge clk);
    checkOutput("sim_cpu_rvalid", cpu_rvalid, 1'b1);
    checkOutput("sim_cpu_rdata", cpu_rdata, 8'h22);
    checkOutput("sim_disp_rvalid_pulse", disp_rvalid, 1'b0);
    repeat (2) @(negedge clk);

    // Display held continuously: the CPU takes the slot masked by disp_ack
    applyStimulus(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0040, 8'h00);
    @(negedge clk);
    checkOutput("hold_disp_ack1", disp_ack, 1'b1);
    checkOutput("hold_cpu_wait1", cpu_wait, 1'b1);
    @(negedge clk);
    checkOutput("hold_cpu_ack", cpu_ack, 1'b1);
    checkOutput("hold_disp_ack_gap", disp_ack, 1'b0);
    checkOutput("hold_cpu_wait2", cpu_wait, 1'b0);
    checkOutput("hold_cpu_addr", mem_addr, 16'h0040);
    applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 8'h00);
    @(negedge clk);
    checkOutput("hold_disp_ack2", disp_ack, 1'b1);
    checkOutput("hold_disp_rvalid", disp_rvalid, 1'b1);
    checkOutput("hold_disp_rdata", disp_rdata, 8'h33);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h00);
    @(negedge clk);
    checkOutput("hold_cpu_rvalid", cpu_rvalid, 1'b1);
    checkOutput("hold_cpu_rdata", cpu_rdata, 8'h44);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the GPU's single-port synchronous video RAM between two requesters: the VGA scanout fetcher (display port) and the CPU register interface (cpu port).
- Display has fixed priority; the CPU port gets every slot the display does not use.
- Issues exactly one RAM access per cycle at most and returns read data with a fixed latency.
- Sits between the gpu bus/register block, the pixel pipeline and the VRAM macro inside the gpu top.

Parameters:
ADDR_W, 16, VRAM address width
DATA_W, 8, VRAM data width
STARVE_LIMIT, 8, cycles a pending CPU request may wait before a forced grant (used only with the optional feature)

Ports:
CLK100MHz  in   1       system clock, all logic on rising edge
rst        in   1       asynchronous active-low reset
disp_req   in   1       display access request, held until disp_ack; read-only
disp_addr  in   ADDR_W  display address, stable while disp_req is high
disp_ack   out  1       one-cycle pulse: display request accepted
disp_rdata out  DATA_W  display read data
disp_rvalid out 1       one-cycle pulse: disp_rdata valid
cpu_req    in   1       CPU access request, held until cpu_ack
cpu_we     in   1       1 = write, 0 = read; stable with cpu_req
cpu_addr   in   ADDR_W  CPU address
cpu_wdata  in   DATA_W  CPU write data
cpu_ack    out  1       one-cycle pulse: CPU request accepted
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid out  1       one-cycle pulse: cpu_rdata valid (reads only)
mem_en     out  1       RAM access strobe
mem_we     out  1       RAM write enable, only meaningful with mem_en
mem_addr   out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in   DATA_W  RAM read data, valid the cycle after mem_en
cpu_wait   out  1       high while cpu_req is pending and not yet acked

Behaviour:
- Reset (rst low, async): all outputs 0. Any in-flight read is discarded; no rvalid follows the release of reset.
- Arbitration is evaluated at each rising edge. A requester is eligible if its req is high and its ack is currently low, so a held req is never granted twice.
- If display is eligible, grant display. Otherwise, if CPU is eligible, grant CPU. Otherwise idle.
- Grant at edge E registers the following for the cycle after E:
  - mem_en=1, mem_addr, mem_we (0 for display, cpu_we for CPU) and mem_wdata (cpu_wdata for a CPU write, else hold the previous value).
  - The corresponding ack=1 in that same cycle.
- Idle edge: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their previous values.
- Read return:
  - mem_rdata is sampled in the cycle after mem_en (RAM latency 1).
  - It is registered into disp_rdata or cpu_rdata, with that port's rvalid high the next cycle, i.e. 2 cycles after ack.
  - A 2-stage tag pipeline (valid, owner) tracks this. rdata holds its value until the next read for that port completes.
- CPU writes: cpu_ack only, no cpu_rvalid.
- Throughput: at most one grant per port every 2 cycles. Back-to-back alternating display/CPU grants are legal, giving a full-rate RAM.
- State machine (registered grant state): IDLE, DISP, CPU. The next state is computed from eligibility each edge. DISP->DISP is impossible because of the ack mask; DISP->CPU happens when the CPU is eligible.
- Simultaneous disp_req and cpu_req rising in the same cycle: display acked first, CPU acked the cycle after (if display does not re-request eligibly).
- cpu_wait = cpu_req & ~cpu_ack, combinational.
- Dropping req before ack is illegal. A bench assertion flags it; the RTL behaviour in that case is undefined.

Optional Feature:
- Macro: VRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - A saturating counter (width clog2(STARVE_LIMIT+1)) increments each cycle cpu_wait is high and clears on cpu_ack or reset.
  - When it reaches STARVE_LIMIT and the CPU is eligible, the next grant goes to the CPU even if the display is eligible. The display is then granted on the following eligible edge.
- Not defined: strict display priority; no counter logic is synthesized.

Test Plan:
- Reset: rst low mid-read (mem_en high) -> all outputs 0 immediately; after release, no disp_rvalid or cpu_rvalid appears.
- Single display read of 0x0123 with RAM pre-loaded 0xA5 -> mem_en/mem_addr=0x0123 and disp_ack in cycle N+1; disp_rdata=0xA5 with disp_rvalid in cycle N+3.
- CPU write 0x4000<=0x3C, then CPU read 0x4000 -> mem_we=1 with mem_wdata=0x3C; no cpu_rvalid for the write; the read returns cpu_rdata=0x3C with cpu_rvalid 2 cycles after its ack.
- Simultaneous requests, display 0x0010 and CPU read 0x0020 -> disp_ack first, cpu_ack the next cycle; both rdata return in the same order with 1-cycle spacing.
- Display req held continuously (re-requesting each ack) plus CPU read pending -> CPU acked within 2 cycles via the alternate slot; cpu_wait high only until then.
- With VRAM_ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: force display eligible every cycle via a model where the display is always eligible -> cpu_ack occurs exactly when the counter reaches 4. Without the macro: cpu_ack occurs only when display is ineligible.
